// File: rtl/systolic_mac_2x2.sv
// 2x2 signed MAC array accumulating C = A*B from streamed operand lanes, then
// draining C11..C22 over a valid/ready port. Define SYSTOLIC_MAC_SAT_EN for saturating accumulation.
module systolic_mac_2x2 #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ACC_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              push11,
   input  logic              pushedge,
   input  logic              push22,
   input  logic              valid,
   input  logic [DATA_W-1:0] a1X,
   input  logic [DATA_W-1:0] a2X,
   input  logic [DATA_W-1:0] bX1,
   input  logic [DATA_W-1:0] bX2,
   output logic [ACC_W-1:0]  res_data,
   output logic [1:0]        res_idx,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              res_last,
   output logic              busy,
   output logic              err
);

   typedef enum logic {ST_ACCUM = 1'b0, ST_DRAIN = 1'b1} state_t;

   state_t                   state_q, state_d;
   logic [ACC_W-1:0]         acc_q [4];
   logic [ACC_W-1:0]         acc_d [4];
   logic [1:0]               idx_q, idx_d;
   logic                     rv_q, rv_d;
   logic                     busy_q, busy_d;
   logic                     err_q, err_d;
   logic                     valid_q, valid_d;

   logic signed [2*DATA_W-1:0] prod [4];
   logic [ACC_W-1:0]         prod_x [4];
   logic [3:0]               strobe;
   logic                     multi;
   logic                     vrise;
   logic [ACC_W-1:0]         base;
   logic [ACC_W:0]           add_r;

`ifdef SYSTOLIC_MAC_SAT_EN
   // Returns {overflow, clamped sum}; overflow when both addends share a sign the sum lacks.
   function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
      logic [ACC_W-1:0] s;
      s = a + b;
      if ((a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1])) begin
         if (a[ACC_W-1]) return {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
         else            return {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
      end
      return {1'b0, s};
   endfunction
`else
   function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
      return {1'b0, ACC_W'(a + b)};
   endfunction
`endif

   // Cell order: 0=C11, 1=C12, 2=C21, 3=C22.
   always_comb begin
      prod[0] = $signed(a1X) * $signed(bX1);
      prod[1] = $signed(a1X) * $signed(bX2);
      prod[2] = $signed(a2X) * $signed(bX1);
      prod[3] = $signed(a2X) * $signed(bX2);
      for (int i = 0; i < 4; i++) prod_x[i] = ACC_W'(prod[i]);
   end

   assign strobe = {push22, pushedge, pushedge, push11};
   assign multi  = (push11 & pushedge) | (push11 & push22) | (pushedge & push22);
   assign vrise  = valid & ~valid_q;

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_ACCUM;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_ACCUM: if (vrise) state_d = ST_DRAIN;
         ST_DRAIN: if (res_ready && (idx_q == 2'd3)) state_d = ST_ACCUM;
         default:  state_d = ST_ACCUM;
      endcase
   end

   always_comb begin
      for (int i = 0; i < 4; i++) acc_d[i] = acc_q[i];
      idx_d   = idx_q;
      rv_d    = rv_q;
      busy_d  = busy_q;
      err_d   = err_q;
      valid_d = valid;
      base    = '0;
      add_r   = '0;
      case (state_q)
         ST_ACCUM: begin
            if (multi) err_d = 1'b1;
            for (int i = 0; i < 4; i++) begin
               base = start ? '0 : acc_q[i];
               if (strobe[i]) begin
                  add_r    = acc_add(base, prod_x[i]);
                  acc_d[i] = add_r[ACC_W-1:0];
                  if (add_r[ACC_W]) err_d = 1'b1;
               end else if (start) begin
                  acc_d[i] = '0;
               end
            end
            if (vrise) begin
               idx_d  = 2'd0;
               rv_d   = 1'b1;
               busy_d = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (start | push11 | pushedge | push22) err_d = 1'b1;
            if (res_ready) begin
               if (idx_q == 2'd3) begin
                  for (int i = 0; i < 4; i++) acc_d[i] = '0;
                  idx_d  = 2'd0;
                  rv_d   = 1'b0;
                  busy_d = 1'b0;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) acc_q[i] <= '0;
         idx_q   <= 2'd0;
         rv_q    <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) acc_q[i] <= acc_d[i];
         idx_q   <= idx_d;
         rv_q    <= rv_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         valid_q <= valid_d;
      end
   end

   // Result word is a live view of the selected accumulator, zero when idle.
   assign res_data  = rv_q ? acc_q[idx_q] : '0;
   assign res_idx   = idx_q;
   assign res_valid = rv_q;
   assign res_last  = rv_q & (idx_q == 2'd3);
   assign busy      = busy_q;
   assign err       = err_q;

endmodule

// File: tb/tb_systolic_mac_2x2.sv
// Directed bench for systolic_mac_2x2: block vector table plus hand sequences for drain corner cases.
module tb_systolic_mac_2x2;

   logic        clk = 1'b0;
   logic        reset, start, push11, pushedge, push22, valid, res_ready;
   logic [7:0]  a1X, a2X, bX1, bX2;
   logic [31:0] res_data;
   logic [1:0]  res_idx;
   logic        res_valid, res_last, busy, err;

   logic        o_start, o_push11, o_valid, o_ready;
   logic [7:0]  o_a1, o_b1;
   logic [15:0] o_data;
   logic [1:0]  o_idx;
   logic        o_rv, o_last, o_busy, o_err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   systolic_mac_2x2 #(.DATA_W(8), .ACC_W(32)) dut (
      .clk(clk), .reset(reset), .start(start), .push11(push11), .pushedge(pushedge),
      .push22(push22), .valid(valid), .a1X(a1X), .a2X(a2X), .bX1(bX1), .bX2(bX2),
      .res_data(res_data), .res_idx(res_idx), .res_valid(res_valid), .res_ready(res_ready),
      .res_last(res_last), .busy(busy), .err(err));

   systolic_mac_2x2 #(.DATA_W(8), .ACC_W(16)) dut16 (
      .clk(clk), .reset(reset), .start(o_start), .push11(o_push11), .pushedge(1'b0),
      .push22(1'b0), .valid(o_valid), .a1X(o_a1), .a2X(8'd0), .bX1(o_b1), .bX2(8'd0),
      .res_data(o_data), .res_idx(o_idx), .res_valid(o_rv), .res_ready(o_ready),
      .res_last(o_last), .busy(o_busy), .err(o_err));

   typedef struct {
      bit st, p11, pe, p22;
      int a1, a2, b1, b2;
      bit drain;
      int e0, e1, e2, e3;
   } vec_t;

   vec_t tbl [7];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic beat(input bit st, input bit p11, input bit pe, input bit p22,
                       input int a1, input int a2, input int b1, input int b2);
      start = st; push11 = p11; pushedge = pe; push22 = p22;
      a1X = 8'(a1); a2X = 8'(a2); bX1 = 8'(b1); bX2 = 8'(b2);
      step();
      start = 0; push11 = 0; pushedge = 0; push22 = 0;
   endtask

   // Raise valid, then hold off acceptance for 'stall' cycles checking idx 0 stays put.
   task automatic start_drain(input int stall, input int e0);
      valid = 1; res_ready = (stall == 0);
      step();
      for (int k = 0; k < stall; k++) begin
         check("stall_valid", int'(res_valid), 1);
         check("stall_idx", int'(res_idx), 0);
         check("stall_data", int'($signed(res_data)), e0);
         step();
      end
   endtask

   // Assumes DRAIN at idx 0; accepts all four words and checks return to ACCUM.
   task automatic drain_check(input int e0, input int e1, input int e2, input int e3);
      int ex [4];
      ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
      res_ready = 1;
      for (int i = 0; i < 4; i++) begin
         check("drain_valid", int'(res_valid), 1);
         check("drain_busy", int'(busy), 1);
         check("drain_idx", int'(res_idx), i);
         check("drain_data", int'($signed(res_data)), ex[i]);
         check("drain_last", int'(res_last), (i == 3) ? 1 : 0);
         step();
      end
      check("post_valid", int'(res_valid), 0);
      check("post_busy", int'(busy), 0);
      valid = 0;
   endtask

   task automatic do_reset();
      reset = 1;
      step();
      reset = 0;
   endtask

   initial begin
      reset = 1; start = 0; push11 = 0; pushedge = 0; push22 = 0; valid = 0; res_ready = 0;
      a1X = 0; a2X = 0; bX1 = 0; bX2 = 0;
      o_start = 0; o_push11 = 0; o_valid = 0; o_ready = 0; o_a1 = 0; o_b1 = 0;
      step(); step();
      reset = 0;

      check("rst_valid", int'(res_valid), 0);
      check("rst_idx", int'(res_idx), 0);
      check("rst_data", int'(res_data), 0);
      check("rst_last", int'(res_last), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_err", int'(err), 0);

      tbl[0] = '{1, 1, 0, 0,    3,    0,   -2,    0, 0,   0,  0,   0,     0};
      tbl[1] = '{0, 0, 1, 0,    5,   -7,    2,    4, 0,   0,  0,   0,     0};
      tbl[2] = '{0, 0, 0, 1,    0, -128,    0, -128, 1,  -6, 20, -14, 16384};
      tbl[3] = '{1, 1, 0, 0,   10,    0,   10,    0, 0,   0,  0,   0,     0};
      tbl[4] = '{0, 1, 0, 0,   -1,    0,  127,    0, 1, -27,  0,   0,     0};
      tbl[5] = '{0, 1, 0, 0,    4,    0,    4,    0, 0,   0,  0,   0,     0};
      tbl[6] = '{1, 0, 0, 1,    0,    3,    0,   -3, 1,   0,  0,   0,    -9};

      for (int v = 0; v < 7; v++) begin
         beat(tbl[v].st, tbl[v].p11, tbl[v].pe, tbl[v].p22, tbl[v].a1, tbl[v].a2, tbl[v].b1, tbl[v].b2);
         if (tbl[v].drain) begin
            start_drain(0, tbl[v].e0);
            drain_check(tbl[v].e0, tbl[v].e1, tbl[v].e2, tbl[v].e3);
            step();
         end
      end
      check("table_err", int'(err), 0);

      // Backpressure: idx 0 held for 5 cycles, then words in order
      beat(1, 1, 0, 0, 2, 0, 3, 0);
      beat(0, 0, 1, 0, 2, 1, 3, 1);
      beat(0, 0, 0, 1, 0, 1, 0, 1);
      start_drain(5, 6);
      drain_check(6, 2, 3, 1);
      step();

      // Push coinciding with the valid rise is included
      beat(1, 0, 0, 1, 0, 1, 0, 1);
      pushedge = 1; a1X = 8'(1); bX2 = 8'(2); a2X = 8'(3); bX1 = 8'(4);
      valid = 1; res_ready = 1;
      step();
      pushedge = 0;
      drain_check(0, 2, 12, 1);
      check("vrise_push_err", int'(err), 0);
      step();

      // Push during DRAIN is ignored and flags err
      beat(1, 1, 0, 0, 3, 0, 3, 0);
      start_drain(1, 9);
      push11 = 1; a1X = 8'(5); bX1 = 8'(5);
      step();
      push11 = 0;
      check("drain_push_err", int'(err), 1);
      drain_check(9, 0, 0, 0);
      step();

      // Two strobes in one ACCUM cycle: both applied, err set
      do_reset();
      beat(1, 1, 0, 1, 2, 3, 2, 3);
      check("multi_err", int'(err), 1);
      start_drain(0, 4);
      drain_check(4, 0, 0, 9);
      step();

      // Reset at idx 2 discards the drain
      beat(1, 1, 0, 0, 7, 0, 7, 0);
      start_drain(0, 49);
      step(); step();
      check("mid_idx", int'(res_idx), 2);
      valid = 0;
      do_reset();
      check("mid_rst_valid", int'(res_valid), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_err", int'(err), 0);
      check("mid_rst_idx", int'(res_idx), 0);
      beat(0, 0, 0, 1, 0, 2, 0, 2);
      start_drain(0, 0);
      drain_check(0, 0, 0, 4);
      step();

      // 16-bit accumulator: three 127*127 beats
      o_start = 1; o_push11 = 1; o_a1 = 8'd127; o_b1 = 8'd127;
      step();
      o_start = 0;
      step(); step();
      o_push11 = 0; o_valid = 1; o_ready = 1;
      step();
      check("ovf_idx", int'(o_idx), 0);
      check("ovf_valid", int'(o_rv), 1);
`ifdef SYSTOLIC_MAC_SAT_EN
      check("ovf_data", int'($signed(o_data)), 32767);
      check("ovf_err", int'(o_err), 1);
`else
      check("ovf_data", int'($signed(o_data)), -17149);
      check("ovf_err", int'(o_err), 0);
`endif
      step(); step(); step(); step();
      check("ovf_done", int'(o_rv), 0);
      o_valid = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/systolic_mac_2x2.md
Name: systolic_mac_2x2

Overview:
- Downstream consumer of the tensor-core streaming state machine: takes the int8 operand lanes (a1X, a2X, bX1, bX2) and the push strobes, and accumulates a 2x2 output block C = A·B in four signed MAC cells.
- When the upstream `valid` rises, it drains the four accumulators one at a time over a valid/ready result port, then clears for the next block.
- Sits between the state machine and the result writeback/readout logic.

Parameters:
- DATA_W, 8: operand width, signed two's complement.
- ACC_W, 32: accumulator and result width, signed. Legal range 2*DATA_W to 48.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; clears all accumulators at the start of a block.
- push11  in  1  accumulate into cell C11.
- pushedge  in  1  accumulate into cells C12 and C21.
- push22  in  1  accumulate into cell C22.
- valid  in  1  upstream operation complete; level signal, rising edge detected internally.
- a1X  in  DATA_W  row-1 A operand.
- a2X  in  DATA_W  row-2 A operand.
- bX1  in  DATA_W  column-1 B operand.
- bX2  in  DATA_W  column-2 B operand.
- res_data  out  ACC_W  result word currently presented.
- res_idx  out  2  result index: 0=C11, 1=C12, 2=C21, 3=C22.
- res_valid  out  1  res_data/res_idx valid.
- res_ready  in  1  consumer accepts the word when res_valid && res_ready.
- res_last  out  1  high together with res_valid when res_idx==3.
- busy  out  1  high while in DRAIN.
- err  out  1  sticky protocol error flag.

Behaviour:
- Reset (synchronous, reset==1 at an edge):
  - all four accumulators = 0
  - state = ACCUM
  - res_valid = 0, res_idx = 0, res_data = 0, res_last = 0, busy = 0, err = 0
  - internal valid_q = 0
- Products:
  - Signed DATA_W x DATA_W full-precision product, sign-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W (see optional feature for saturation).
- ACCUM state, evaluated at each edge:
  - push11: C11 += a1X*bX1
  - pushedge: C12 += a1X*bX2 and C21 += a2X*bX1 (both updated in the same cycle)
  - push22: C22 += a2X*bX2
  - Latency 1: the updated accumulator is visible the cycle after the strobe.
- More than one push strobe high in the same cycle:
  - Every asserted strobe is applied.
  - err is set (upstream contract violation).
- start in ACCUM:
  - Every accumulator loads 0 plus its product if its strobe is asserted in the same cycle.
  - start has priority over the prior value, not over the product.
- Drain entry:
  - Rising-edge detect: vrise = valid && !valid_q; valid_q <= valid every cycle.
  - vrise in ACCUM → next state DRAIN, res_idx = 0, res_valid = 1, busy = 1.
  - A push in the same cycle as vrise is accumulated first and is included in the drained value.
- DRAIN state:
  - res_data is a combinational mux of the accumulator selected by res_idx.
  - res_data, res_idx and res_last are held stable while res_valid && !res_ready.
  - On accept with res_idx < 3: res_idx increments.
  - On accept with res_idx == 3: all accumulators cleared, res_valid = 0, busy = 0, res_idx = 0, state = ACCUM.
- Events during DRAIN:
  - Any push strobe or start is ignored (accumulators unchanged) and err is set.
  - vrise is ignored.
- Minimum drain length: 4 cycles with res_ready held high.
- err is cleared only by reset.
- Reset mid-DRAIN: immediate return to the reset state; pending results are discarded.

Optional Feature:
- Macro: SYSTOLIC_MAC_SAT_EN
- Defined: each accumulation saturates.
  - Sum > 2^(ACC_W-1)-1 clamps to the maximum.
  - Sum < -2^(ACC_W-1) clamps to the minimum.
  - Overflow is detected from the sign bits of the addend, the accumulator and the sum.
  - A saturating event sets err.
- Not defined: plain wrap-around addition, and err is never set by overflow.

Test Plan:
- Basic MACs: after reset and start, apply
  - push11 with a1X=3, bX1=-2
  - pushedge with a1X=5, bX2=4, a2X=-7, bX1=2
  - push22 with a2X=-128, bX2=-128
  - raise valid, res_ready=1
  → results (idx, value) (0,-6), (1,20), (2,-14), (3,16384) on 4 consecutive cycles; res_last only on idx 3; busy low afterwards; err=0.
- Accumulation across beats: two push11 beats (10,10) then (-1,127) → C11=-27 drained at idx 0; the other cells drain 0.
- Backpressure: hold res_ready=0 for 5 cycles during DRAIN → idx 0 and res_data stable throughout; then res_ready=1 → remaining words in order with no loss or duplication.
- Protocol errors:
  - push11 during DRAIN → C11 unchanged, err=1.
  - push11 and push22 in the same cycle in ACCUM → both cells updated, err=1.
- Reset mid-drain: assert reset at idx 2 → res_valid=0, all accumulators 0, err=0 the next cycle; a new block then drains correctly.
- Overflow, ACC_W=16, three push11 beats of 127*127:
  - Without SYSTOLIC_MAC_SAT_EN → C11 = -17149, err=0.
  - With SYSTOLIC_MAC_SAT_EN → C11 = 32767, err=1.
